// File: rtl/router_pkg.sv
// Shared definitions for the router FIFO: default geometry, header field
// positions and the packet-length helper used by the read-side counter.
package router_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Header byte layout: destination address in the low bits, payload length above
   localparam int ADDR_HI = 1;
   localparam int ADDR_LO = 0;
   localparam int LEN_HI  = 7;
   localparam int LEN_LO  = 2;

   // Packet counter: 6-bit length plus one parity byte needs 7 bits
   localparam int CNT_W = 7;

   // Bytes still to be delivered after a header: payload length plus parity
   function automatic logic [CNT_W-1:0] pkt_load(input logic [7:0] hdr);
      return CNT_W'({1'b0, hdr[LEN_HI:LEN_LO]}) + CNT_W'(1);
   endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for the router FIFO: DEPTH entries of {hdr flag, data byte}.
// Synchronous write, combinational read. Only the header flags are cleared;
// the data bytes are never read before being rewritten after a clear.
module router_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic                       write_en,
   input  logic [$clog2(DEPTH)-1:0]   write_addr,
   input  logic [WIDTH:0]             write_data,
   input  logic [$clog2(DEPTH)-1:0]   read_addr,
   output logic [WIDTH:0]             read_data
);

   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0] hdr_mem;

   // Data byte storage, written on an accepted push
   always_ff @(posedge clock) begin
      if (write_en) data_mem[write_addr] <= write_data[WIDTH-1:0];
   end

   // Header flag storage, wiped by any reset or flush
   always_ff @(posedge clock) begin
      if (clear)         hdr_mem <= '0;
      else if (write_en) hdr_mem[write_addr] <= write_data[WIDTH];
   end

   assign read_data = {hdr_mem[read_addr], data_mem[read_addr]};

endmodule

// File: rtl/router_fifo.sv
// Router output FIFO: stores {header flag, byte}, delivers bytes with a
// one-cycle registered read and tracks the remaining bytes of the current
// packet so data_out returns to 00 once a packet has been fully drained.
// Reset: resetn is synchronous and active-high.
// Option: define ROUTER_FIFO_SOFT_RESET_EN to add the soft_reset flush port.
module router_fifo
   import router_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clock,
   input  logic             resetn,
`ifdef ROUTER_FIFO_SOFT_RESET_EN
   input  logic             soft_reset,
`endif
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   rd_entry;
   logic             clear;
   logic             do_write;
   logic             do_read;

`ifdef ROUTER_FIFO_SOFT_RESET_EN
   assign clear = resetn | soft_reset;
`else
   assign clear = resetn;
`endif

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_write = write_enb && !full;
   assign do_read  = read_enb && !empty;

   router_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clock      (clock),
      .clear      (clear),
      .write_en   (do_write && !clear),
      .write_addr (wr_ptr[AW-1:0]),
      .write_data ({lfd_state, data_in}),
      .read_addr  (rd_ptr[AW-1:0]),
      .read_data  (rd_entry)
   );

   // Pointer advance on accepted writes and reads; clear overrides both
   always_ff @(posedge clock) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Packet byte counter: loaded from a header, counts down on payload reads
   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else if (do_read) begin
         if (rd_entry[WIDTH])   count <= pkt_load(rd_entry[7:0]);
         else if (count != '0) count <= count - CNT_ONE;
      end
   end

   // Registered read data; idles at 00 between packets instead of floating
   always_ff @(posedge clock) begin
      if (clear)              data_out <= '0;
      else if (do_read)       data_out <= rd_entry[WIDTH-1:0];
      else if (count == '0)   data_out <= '0;
   end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based reference model, directed
// scenarios plus randomized traffic, scoreboard checked by a separate monitor.
module tb_router_fifo;

   localparam int W = 8;
   localparam int D = 16;

   typedef struct {
      logic [7:0] dout;
      logic       full;
      logic       empty;
   } exp_t;

   logic         clock = 1'b0;
   logic         resetn;
`ifdef ROUTER_FIFO_SOFT_RESET_EN
   logic         soft_reset;
`endif
   logic         write_enb;
   logic         read_enb;
   logic         lfd_state;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         full;
   logic         empty;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [8:0] mq[$];
   int         m_cnt;
   logic [7:0] m_dout;
   exp_t       exp_q[$];

   router_fifo #(.WIDTH(W), .DEPTH(D)) dut (
      .clock      (clock),
      .resetn     (resetn),
`ifdef ROUTER_FIFO_SOFT_RESET_EN
      .soft_reset (soft_reset),
`endif
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model one clock edge from the rules: queue of entries, packet byte counter
   task automatic model_step(input logic rst, input logic sr, input logic we,
                             input logic re, input logic lfd, input logic [7:0] din);
      logic       rd, wr;
      logic [8:0] e;
      if (rst || sr) begin
         mq.delete();
         m_cnt  = 0;
         m_dout = 8'h00;
      end else begin
         rd = re && (mq.size() != 0);
         wr = we && (mq.size() != D);
         if (rd) begin
            e = mq.pop_front();
            m_dout = e[7:0];
            if (e[8])           m_cnt = int'(e[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
         end else if (m_cnt == 0) begin
            m_dout = 8'h00;
         end
         if (wr) mq.push_back({lfd, din});
      end
   endtask

   task automatic cycle(input logic rst, input logic sr, input logic we,
                        input logic re, input logic lfd, input logic [7:0] din);
      exp_t x;
      logic sr_eff;
      resetn    = rst;
`ifdef ROUTER_FIFO_SOFT_RESET_EN
      soft_reset = sr;
      sr_eff     = sr;
`else
      sr_eff     = 1'b0;
`endif
      write_enb = we;
      read_enb  = re;
      lfd_state = lfd;
      data_in   = din;
      model_step(rst, sr_eff, we, re, lfd, din);
      x.dout  = m_dout;
      x.full  = (mq.size() == D);
      x.empty = (mq.size() == 0);
      @(posedge clock);
      exp_q.push_back(x);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wr(input logic lfd, input logic [7:0] din);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, lfd, din);
   endtask

   task automatic rd();
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Scoreboard monitor: compares every presented output against the model
   initial begin
      exp_t x;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("sb_data_out", 32'(data_out), 32'(x.dout));
            check("sb_full",     32'(full),     32'(x.full));
            check("sb_empty",    32'(empty),    32'(x.empty));
         end
      end
   end

   initial begin
      logic [7:0] seq[5];
      logic [7:0] pat[D];
      resetn = 1'b1; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; data_in = '0;
`ifdef ROUTER_FIFO_SOFT_RESET_EN
      soft_reset = 1'b0;
`endif
      m_cnt = 0; m_dout = 8'h00;

      // reset state
      do_reset();
      do_reset();
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_full",  32'(full),  32'd0);
      check("reset_dout",  32'(data_out), 32'h00);

      // single packet: header 0D (len 3), three payload, parity
      seq[0] = 8'h0D; seq[1] = 8'h11; seq[2] = 8'h22; seq[3] = 8'h33; seq[4] = 8'h5A;
      wr(1'b1, seq[0]);
      for (int i = 1; i < 5; i++) wr(1'b0, seq[i]);
      for (int i = 0; i < 5; i++) begin
         rd();
         check($sformatf("pkt_byte%0d", i), 32'(data_out), 32'(seq[i]));
      end
      idle();
      check("pkt_tail_zero", 32'(data_out), 32'h00);
      check("pkt_tail_empty", 32'(empty), 32'd1);

      // fill, overflow write dropped, drain in order
      do_reset();
      for (int i = 0; i < D; i++) begin
         pat[i] = 8'($urandom_range(1, 254));
         if (pat[i] == 8'hAA) pat[i] = 8'h55;
         wr(1'b0, pat[i]);
      end
      check("fill_full", 32'(full), 32'd1);
      wr(1'b0, 8'hAA);
      check("ovf_full", 32'(full), 32'd1);
      for (int i = 0; i < D; i++) begin
         rd();
         check($sformatf("drain%0d", i), 32'(data_out), 32'(pat[i]));
      end
      check("drain_empty", 32'(empty), 32'd1);

      // full with simultaneous read and write
      for (int i = 0; i < D; i++) wr(1'b0, 8'(i + 8'h40));
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
      check("full_rw_dout", 32'(data_out), 32'h40);
      check("full_rw_full", 32'(full), 32'd0);
      for (int i = 0; i < D - 1; i++) rd();
      check("full_rw_empty", 32'(empty), 32'd1);

      // empty with simultaneous read and write
      idle();
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
      check("empty_rw_dout", 32'(data_out), 32'h00);
      check("empty_rw_empty", 32'(empty), 32'd0);
      rd();
      check("empty_rw_read", 32'(data_out), 32'h77);

      // pointer wrap: 10 in, 10 out, 16 in, 16 out
      do_reset();
      for (int i = 0; i < 10; i++) wr(1'b0, 8'($urandom));
      for (int i = 0; i < 10; i++) rd();
      for (int i = 0; i < D; i++) wr(1'b0, 8'($urandom));
      check("wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < D; i++) rd();
      check("wrap_empty", 32'(empty), 32'd1);

`ifdef ROUTER_FIFO_SOFT_RESET_EN
      // flush mid-packet
      wr(1'b1, 8'h15);
      for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'h90 + i));
      for (int i = 0; i < 3; i++) rd();
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hCC);
      check("soft_empty", 32'(empty), 32'd1);
      check("soft_dout",  32'(data_out), 32'h00);
      idle();
      check("soft_idle_dout", 32'(data_out), 32'h00);
`endif

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 99) < 2), 1'b0,
               ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
               ($urandom_range(0, 99) < 15), 8'($urandom));
      end
      for (int i = 0; i < D + 2; i++) rd();

      @(negedge clock);
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
